// File: rtl/reg16_en.sv
// Load-enabled datapath register (PC, IR, MAR, MDR, general registers).
// Assembled from per-bit enabled D flip-flop cells with synchronous active-low reset.

module reg16_en_bit #(
  parameter logic RV = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins over enable; with en low the cell holds, so an unknown d cannot leak in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RV;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module reg16_en #(
  parameter int              WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < 1) begin : g_width_check
    $error("reg16_en: WIDTH must be >= 1");
  end

  // RST_VAL is typed to WIDTH bits, so a wider override keeps only its LSBs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg16_en_bit #(
      .RV(RST_VAL[i])
    ) u_bit (
      .clk  (clk),
      .rst_n(reset),
      .en   (en),
      .d    (D[i]),
      .q    (Q[i])
    );
  end

endmodule

// File: tb/tb_reg16_en.sv
// Directed bench for reg16_en: default 16-bit instance plus an 8-bit instance with non-zero reset value.

module tb_reg16_en;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] d;
  logic [15:0] q;

  logic        reset8;
  logic        en8;
  logic [7:0]  d8;
  logic [7:0]  q8;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  reg16_en dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .D    (d),
    .Q    (q)
  );

  reg16_en #(
    .WIDTH  (8),
    .RST_VAL(8'hA5)
  ) dut8 (
    .clk  (clk),
    .reset(reset8),
    .en   (en8),
    .D    (d8),
    .Q    (q8)
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic e, input logic [15:0] v);
    @(negedge clk);
    reset = r;
    en    = e;
    d     = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 16'hBEEF);
    after_edge();
    total_cnt++;
    if (q !== 16'h0000) $display("FAIL reset_over_en: got %h want 0000", q);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'hBEEF);
      after_edge();
      total_cnt++;
      if (q !== 16'h0000) $display("FAIL reset_hold_%0d: got %h want 0000", i, q);
      else pass_cnt++;
    end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 16'h3000);
    #1;
    total_cnt++;
    if (q !== 16'h0000) $display("FAIL load_before_edge: got %h want 0000", q);
    else pass_cnt++;
    after_edge();
    total_cnt++;
    if (q !== 16'h3000) $display("FAIL load_after_edge: got %h want 3000", q);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    logic [15:0] pat [3];
    pat[0] = 16'h1234;
    pat[1] = 16'hFFFF;
    pat[2] = 16'hxxxx;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, pat[i % 3]);
      after_edge();
      total_cnt++;
      if (q !== 16'h3000) $display("FAIL hold_%0d: got %h want 3000", i, q);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vec [3];
    vec[0] = 16'h0001;
    vec[1] = 16'h0002;
    vec[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, vec[i]);
      after_edge();
      total_cnt++;
      if (q !== vec[i]) $display("FAIL b2b_%0d: got %h want %h", i, q, vec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 1'b1, 16'h5555);
    after_edge();
    total_cnt++;
    if (q !== 16'h0000) $display("FAIL prio_reset: got %h want 0000", q);
    else pass_cnt++;
    drive(1'b1, 1'b1, 16'h5555);
    after_edge();
    total_cnt++;
    if (q !== 16'h5555) $display("FAIL prio_resume: got %h want 5555", q);
    else pass_cnt++;
  endtask

  task automatic test_sync_glitch();
    drive(1'b1, 1'b0, 16'h0000);
    #1;
    reset = 1'b0;
    #2;
    total_cnt++;
    if (q !== 16'h5555) $display("FAIL glitch_during: got %h want 5555", q);
    else pass_cnt++;
    reset = 1'b1;
    after_edge();
    total_cnt++;
    if (q !== 16'h5555) $display("FAIL glitch_after_edge: got %h want 5555", q);
    else pass_cnt++;
  endtask

  task automatic test_zero_store();
    drive(1'b1, 1'b1, 16'h0000);
    after_edge();
    total_cnt++;
    if (q !== 16'h0000) $display("FAIL store_zero: got %h want 0000", q);
    else pass_cnt++;
  endtask

  task automatic test_param();
    @(negedge clk);
    reset8 = 1'b0;
    en8    = 1'b1;
    d8     = 8'h3C;
    after_edge();
    total_cnt++;
    if (q8 !== 8'hA5) $display("FAIL param_reset: got %h want a5", q8);
    else pass_cnt++;
    @(negedge clk);
    reset8 = 1'b1;
    after_edge();
    total_cnt++;
    if (q8 !== 8'h3C) $display("FAIL param_load: got %h want 3c", q8);
    else pass_cnt++;
    @(negedge clk);
    en8 = 1'b0;
    d8  = 8'hFF;
    after_edge();
    total_cnt++;
    if (q8 !== 8'h3C) $display("FAIL param_hold: got %h want 3c", q8);
    else pass_cnt++;
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    d      = '0;
    reset8 = 1'b1;
    en8    = 1'b0;
    d8     = '0;
    test_reset();
    test_load();
    test_hold();
    test_back_to_back();
    test_reset_priority();
    test_sync_glitch();
    test_zero_store();
    test_param();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
